// File: rtl/pb_conditioner.sv
// Pushbutton front end: per-channel synchronizer, debounce FSM and
// press/release/hold event strobes for the LED pattern logic.
module pb_conditioner #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned ACTIVE_LOW      = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 50000000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] pb_raw,
   output logic [WIDTH-1:0] pb_clean,
   output logic [WIDTH-1:0] pb_press,
   output logic [WIDTH-1:0] pb_release,
   output logic [WIDTH-1:0] pb_hold,
   output logic             any_press
);

   localparam logic [WIDTH-1:0] INV_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic             HOLD_EN   = (HOLD_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] clean_nx;
   logic [WIDTH-1:0] press_nx;
   logic [WIDTH-1:0] release_nx;
   logic [WIDTH-1:0] hold_nx;

   // Two-flop synchronizer on the polarity-normalized pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pb_raw ^ INV_MASK;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] dcnt_q, dcnt_d;
      logic [CNT_W-1:0] hcnt_q, hcnt_d;
      logic             hold_done_q, hold_done_d;
      logic             press_c, release_c, hold_c;

      // Channel state and counters
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            hold_done_q <= 1'b0;
         end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            hold_done_q <= hold_done_d;
         end
      end

      // Debounce transitions; hcnt freezes outside PRESSED so a
      // bounced release cannot re-arm the hold event
      always_comb begin
         state_d     = state_q;
         dcnt_d      = dcnt_q;
         hcnt_d      = hcnt_q;
         hold_done_d = hold_done_q;
         case (state_q)
            IDLE: begin
               if (sync2[i]) begin
                  state_d = PRESS_WAIT;
                  dcnt_d  = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync2[i]) begin
                  state_d = IDLE;
               end else if (dcnt_q == DB_LAST) begin
                  state_d     = PRESSED;
                  hcnt_d      = '0;
                  hold_done_d = 1'b0;
               end else begin
                  dcnt_d = dcnt_q + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!sync2[i]) begin
                  state_d = RELEASE_WAIT;
                  dcnt_d  = '0;
               end else if (HOLD_EN && !hold_done_q && hcnt_q == HOLD_LAST) begin
                  hold_done_d = 1'b1;
               end else if (!hold_done_q && hcnt_q != '1) begin
                  hcnt_d = hcnt_q + CNT_W'(1);
               end
            end
            RELEASE_WAIT: begin
               if (sync2[i]) begin
                  state_d = PRESSED;
               end else if (dcnt_q == DB_LAST) begin
                  state_d = IDLE;
               end else begin
                  dcnt_d = dcnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Event decode for the next registered output values
      always_comb begin
         press_c   = 1'b0;
         release_c = 1'b0;
         hold_c    = 1'b0;
         case (state_q)
            PRESS_WAIT:
               press_c = sync2[i] && (dcnt_q == DB_LAST);
            PRESSED:
               hold_c = sync2[i] && HOLD_EN && !hold_done_q && (hcnt_q == HOLD_LAST);
            RELEASE_WAIT:
               release_c = !sync2[i] && (dcnt_q == DB_LAST);
            default: ;
         endcase
      end

      assign clean_nx[i]   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      assign press_nx[i]   = press_c;
      assign release_nx[i] = release_c;
      assign hold_nx[i]    = hold_c;
   end

   // Registered outputs; en masks the strobes only, never the level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pb_clean   <= '0;
         pb_press   <= '0;
         pb_release <= '0;
         pb_hold    <= '0;
         any_press  <= 1'b0;
      end else begin
         pb_clean   <= clean_nx;
         pb_press   <= press_nx & {WIDTH{en}};
         pb_release <= release_nx & {WIDTH{en}};
         pb_hold    <= hold_nx & {WIDTH{en}};
         any_press  <= |(press_nx & {WIDTH{en}});
      end
   end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random bouncing,
// checked against a run-length model of the debounce rules.
module tb_pb_conditioner;

   localparam int unsigned W = 2;
   localparam int unsigned D = 4;
   localparam int unsigned H = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [W-1:0] pb_raw;
   logic [W-1:0] pb_clean, pb_press, pb_release, pb_hold;
   logic         any_press;

   int nchecks = 0;
   int nerrors = 0;

   pb_conditioner #(
      .WIDTH(W), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pb_raw(pb_raw),
      .pb_clean(pb_clean), .pb_press(pb_press), .pb_release(pb_release),
      .pb_hold(pb_hold), .any_press(any_press)
   );

   always #5 clk = ~clk;

   // Reference model: two-sample delay line, accepted level, length of the
   // current run of samples disagreeing with it, and hold progress.
   logic [W-1:0] m_s1, m_s2, m_clean;
   int           m_run [W];
   int           m_hc  [W];
   bit           m_hd  [W];
   logic [8:0]   exp_all;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_clean = '0;
      for (int i = 0; i < int'(W); i++) begin
         m_run[i] = 0; m_hc[i] = 0; m_hd[i] = 1'b0;
      end
      exp_all = '0;
   endtask

   task automatic model_step(input logic [W-1:0] r, input logic e);
      logic [W-1:0] y, p, rl, h;
      y = m_s2; m_s2 = m_s1; m_s1 = r;
      p = '0; rl = '0; h = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (y[i] != m_clean[i]) begin
            m_run[i]++;
            if (m_run[i] == int'(D) + 1) begin
               m_clean[i] = y[i];
               m_run[i]   = 0;
               if (y[i]) begin
                  p[i] = 1'b1; m_hc[i] = 0; m_hd[i] = 1'b0;
               end else begin
                  rl[i] = 1'b1;
               end
            end
         end else begin
            // steady pressed sample (not a return from a release bounce)
            if (m_clean[i] && m_run[i] == 0 && H != 0 && !m_hd[i]) begin
               if (m_hc[i] == int'(H) - 1) begin
                  h[i] = 1'b1; m_hd[i] = 1'b1;
               end else begin
                  m_hc[i]++;
               end
            end
            m_run[i] = 0;
         end
      end
      if (!e) begin p = '0; rl = '0; h = '0; end
      exp_all = {m_clean, p, rl, h, |p};
   endtask

   function automatic logic [8:0] dut_all();
      return {pb_clean, pb_press, pb_release, pb_hold, any_press};
   endfunction

   // One clock: drive at negedge, advance the model at posedge, settle 1ns
   task automatic tick(input logic [W-1:0] r, input logic e);
      @(negedge clk);
      pb_raw = r; en = e;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(r, e);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pb_raw = '0; en = 1'b1;
      model_reset();
      tick(2'b11, 1'b1);
      tick(2'b11, 1'b1);
      nchecks++;
      if (dut_all() !== 9'd0) begin
         nerrors++; $display("FAIL reset_outputs got %b exp %b", dut_all(), 9'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(2'b00, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL reset_idle t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
      end
   endtask

   task automatic test_clean_press();
      int press_at = 0, hold_at = 0, np = 0, nh = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(2'b01, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL press_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_press[0]) begin np++; press_at = k; end
         if (pb_hold[0])  begin nh++; hold_at = k; end
      end
      nchecks++;
      if (press_at != int'(D) + 3 || np != 1) begin
         nerrors++; $display("FAIL press_latency got edge %0d count %0d exp edge %0d count 1", press_at, np, D + 3);
      end
      nchecks++;
      if (hold_at != int'(D + 3 + H) || nh != 1) begin
         nerrors++; $display("FAIL hold_latency got edge %0d count %0d exp edge %0d count 1", hold_at, nh, D + 3 + H);
      end
      for (int k = 0; k < 12; k++) begin
         tick(2'b00, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL press_rel_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [25];
      int   ev = 0, seen_clean = 0;
      for (int k = 0; k < 25; k++) pat[k] = 1'b0;
      for (int k = 0; k < 8; k++) pat[k] = ((k / 2) % 2 == 0);
      for (int k = 14; k < 17; k++) pat[k] = 1'b1;
      for (int k = 0; k < 25; k++) begin
         tick({pat[k], 1'b0}, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL bounce_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_press[1] || pb_release[1] || pb_hold[1]) ev++;
         if (pb_clean[1]) seen_clean++;
      end
      nchecks++;
      if (ev != 0 || seen_clean != 0) begin
         nerrors++; $display("FAIL bounce_reject got strobes %0d clean %0d exp 0 0", ev, seen_clean);
      end
   endtask

   task automatic test_release_glitch();
      int nrel = 0, rel_at = 0, nh = 0;
      logic [W-1:0] seq [44];
      for (int k = 0; k < 44; k++) seq[k] = 2'b01;
      seq[20] = 2'b00; seq[21] = 2'b00;
      for (int k = 32; k < 44; k++) seq[k] = 2'b00;
      for (int k = 0; k < 44; k++) begin
         tick(seq[k], 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL glitch_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_release[0]) begin nrel++; rel_at = k - 31; end
         if (k >= 20 && pb_hold[0]) nh++;
      end
      nchecks++;
      if (nrel != 1 || rel_at != int'(D) + 3) begin
         nerrors++; $display("FAIL release_glitch got count %0d edge %0d exp count 1 edge %0d", nrel, rel_at, D + 3);
      end
      nchecks++;
      if (nh != 0 || pb_clean[0] !== 1'b0) begin
         nerrors++; $display("FAIL glitch_hold got extra holds %0d clean %b exp 0 0", nh, pb_clean[0]);
      end
   endtask

   task automatic test_simultaneous();
      int both_at = 0, nany = 0;
      for (int k = 1; k <= 10; k++) begin
         tick(2'b11, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL simul_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_press == 2'b11) both_at = k;
         if (any_press) nany++;
      end
      nchecks++;
      if (both_at != int'(D) + 3 || nany != 1) begin
         nerrors++; $display("FAIL simultaneous got edge %0d any_press count %0d exp edge %0d count 1", both_at, nany, D + 3);
      end
      for (int k = 0; k < 12; k++) begin
         tick(2'b00, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL simul_rel_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
      end
   endtask

   task automatic test_enable();
      int ev = 0, seen_clean = 0;
      for (int k = 0; k < 40; k++) begin
         tick((k < 20) ? 2'b01 : 2'b00, (k < 30) ? 1'b0 : 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL enable_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_press != 0 || pb_release != 0 || pb_hold != 0 || any_press) ev++;
         if (pb_clean[0]) seen_clean++;
      end
      nchecks++;
      if (ev != 0 || seen_clean == 0 || pb_clean[0] !== 1'b0) begin
         nerrors++; $display("FAIL enable_gating got strobes %0d clean cycles %0d final clean %b exp 0 >0 0", ev, seen_clean, pb_clean[0]);
      end
   endtask

   task automatic test_reset_mid_press();
      int press_at = 0, nrel = 0;
      for (int k = 0; k < 12; k++) tick(2'b01, 1'b1);
      nchecks++;
      if (pb_clean[0] !== 1'b1) begin
         nerrors++; $display("FAIL midrst_pre got clean %b exp 1", pb_clean[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      nchecks++;
      if (dut_all() !== 9'd0) begin
         nerrors++; $display("FAIL midrst_async got %b exp %b", dut_all(), 9'd0);
      end
      tick(2'b01, 1'b1);
      tick(2'b01, 1'b1);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(2'b01, 1'b1);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL midrst_model t=%0t got %b exp %b", $time, dut_all(), exp_all);
         end
         if (pb_press[0]) press_at = k;
         if (pb_release != 0) nrel++;
      end
      nchecks++;
      if (press_at != int'(D) + 3 || nrel != 0) begin
         nerrors++; $display("FAIL midrst_repress got edge %0d releases %0d exp edge %0d releases 0", press_at, nrel, D + 3);
      end
      for (int k = 0; k < 12; k++) tick(2'b00, 1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0] lvl = '0;
      int           left [W];
      logic         e;
      for (int i = 0; i < int'(W); i++) left[i] = 1;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < int'(W); i++) begin
            left[i]--;
            if (left[i] <= 0) begin
               lvl[i]  = ~lvl[i];
               left[i] = int'($urandom_range(1, 20));
            end
         end
         e = ($urandom_range(0, 7) != 0);
         tick(lvl, e);
         nchecks++;
         if (dut_all() !== exp_all) begin
            nerrors++; $display("FAIL random t=%0t raw %b en %b got %b exp %b", $time, lvl, e, dut_all(), exp_all);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_simultaneous();
      test_enable();
      test_reset_mid_press();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
